// File: rtl/tqvp_scanned_hex_display_if.sv
// Peripheral register bus shared by the tqvp_* blocks.
// Handshake: a write is a single-cycle data_write strobe with address and
// data_in valid in the same cycle; the slave always accepts it (no ready).
// data_out is a combinational function of address and is valid whenever
// address is stable.
interface tqvp_scanned_hex_display_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output address, output data_write, output data_in, input data_out);
    modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_scanned_hex_display.sv
// Scanned hex 7-segment display driver: double-buffered digit RAM, per-digit
// PWM brightness, ripple-blank of leading zeros, decimal points and a frame
// sync pin. The STATUS register exposes the scan state (pending, digit, phase).
module tqvp_scanned_hex_display #(
    parameter int NUM_DIGITS = 4,
    parameter int PRE_SHIFT  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    tqvp_scanned_hex_display_if.slave bus
);
    localparam int         PW       = PRE_SHIFT + 9;
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam logic [7:0] DIG_MASK = 8'((1 << NUM_DIGITS) - 1);

    // Unused entries above NUM_DIGITS stay at their reset value of zero.
    logic [3:0]    shadow_q [8];
    logic [3:0]    active_q [8];
    logic [7:0]    dp_q, ctrl_q, prescale_q;
    logic [3:0]    bright_q;
    logic          pending_q;
    logic [PW-1:0] pre_cnt_q;
    logic [3:0]    phase_q;
    logic [2:0]    idx_q;

    logic          en, lt, bi, pol, rbz, sync;
    logic [PW-1:0] pre_limit;
    logic          tick, frame_end, do_swap;
    logic          wr;
    logic [3:0]    waddr;
    logic [7:0]    wdata;
    logic [7:0]    uo_next;

    assign en   = ctrl_q[7];
    assign lt   = ctrl_q[6];
    assign bi   = ctrl_q[5];
    assign pol  = ctrl_q[4];
    assign rbz  = ctrl_q[3];
    assign sync = ctrl_q[2];

    assign wr    = bus.data_write;
    assign waddr = bus.address;
    assign wdata = bus.data_in;

    assign pre_limit = ((PW'(prescale_q) + PW'(1)) << PRE_SHIFT) - PW'(1);
    assign tick      = en && (pre_cnt_q >= pre_limit);
    assign frame_end = tick && (phase_q == 4'hF) && (idx_q == LAST_IDX);
    // With scanning stopped there is no frame boundary to wait for.
    assign do_swap   = pending_q && (frame_end || !en);

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    // Bus-visible registers and the shadow->active buffer swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                shadow_q[k] <= 4'h0;
                active_q[k] <= 4'h0;
            end
            dp_q       <= 8'h00;
            ctrl_q     <= 8'h70;
            prescale_q <= 8'h3F;
            bright_q   <= 4'hF;
            pending_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (wr && waddr == 4'(k / 2))
                    shadow_q[k] <= (k % 2 == 1) ? wdata[7:4] : wdata[3:0];
            end
            if (wr && waddr == 4'h4) dp_q       <= wdata & DIG_MASK;
            if (wr && waddr == 4'h5) ctrl_q     <= wdata;
            if (wr && waddr == 4'h6) prescale_q <= wdata;
            if (wr && waddr == 4'h7) bright_q   <= wdata[3:0];
            // Swap copies the pre-write shadow; a same-cycle write lands in shadow only.
            if (do_swap) begin
                for (int k = 0; k < NUM_DIGITS; k++) active_q[k] <= shadow_q[k];
                pending_q <= 1'b0;
            end else if (wr && waddr == 4'h9 && wdata[0]) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Prescaler, PWM phase and digit scan counters; all held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            phase_q   <= 4'h0;
            idx_q     <= 3'd0;
        end else if (!en) begin
            pre_cnt_q <= '0;
            phase_q   <= 4'h0;
            idx_q     <= 3'd0;
        end else if (tick) begin
            pre_cnt_q <= '0;
            phase_q   <= phase_q + 4'h1;
            if (phase_q == 4'hF)
                idx_q <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end else begin
            pre_cnt_q <= pre_cnt_q + PW'(1);
        end
    end

    // Segment pipeline: decode, PWM gate, leading-zero blank, then LT/BI/POL.
    always_comb begin
        logic [6:0] seg;
        logic [7:0] body;
        logic       lit;
        logic       blank;
        seg   = 7'h00;
        body  = 8'h00;
        lit   = (phase_q <= bright_q);
        blank = 1'b0;
        if (rbz && idx_q != 3'd0) begin
            blank = 1'b1;
            for (int k = 0; k < NUM_DIGITS; k++)
                if (3'(k) >= idx_q && active_q[k] != 4'h0) blank = 1'b0;
        end
        seg = hex7(active_q[idx_q]) & {7{lit}};
        if (blank) seg = 7'h00;
        body = ({dp_q[idx_q] & lit, seg} | {8{~lt}}) & {8{bi}};
        // Frame sync ignores PWM, LT and BI; polarity still applies below.
        if (sync) body[7] = (idx_q == 3'd0);
        if (!en) uo_next = {8{~pol}};
        else     uo_next = body ^ {8{~pol}};
    end

    // Registered pin drive; reset forces all pins low without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uo_out <= 8'h00;
        else        uo_out <= uo_next;
    end

    // Combinational register read-back.
    always_comb begin
        case (bus.address)
            4'h0:    bus.data_out = {shadow_q[1], shadow_q[0]};
            4'h1:    bus.data_out = {shadow_q[3], shadow_q[2]};
            4'h2:    bus.data_out = {shadow_q[5], shadow_q[4]};
            4'h3:    bus.data_out = {shadow_q[7], shadow_q[6]};
            4'h4:    bus.data_out = dp_q;
            4'h5:    bus.data_out = ctrl_q;
            4'h6:    bus.data_out = prescale_q;
            4'h7:    bus.data_out = {4'h0, bright_q};
            4'h8:    bus.data_out = {pending_q, idx_q, phase_q};
            4'h9:    bus.data_out = 8'h00;
            4'hA:    bus.data_out = ui_in;
            default: bus.data_out = 8'hFF;
        endcase
    end
endmodule

// File: tb/tb_tqvp_scanned_hex_display.sv
// Bench for tqvp_scanned_hex_display: register reset/read-back, scanning,
// PWM duty, ripple blanking, buffer swap timing, frame sync and async reset.
module tb_tqvp_scanned_hex_display;
    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'hA5;
    logic [7:0] uo_out;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];

    tqvp_scanned_hex_display_if bus_if ();

    tqvp_scanned_hex_display #(.NUM_DIGITS(4), .PRE_SHIFT(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .bus    (bus_if)
    );

    // Clock and reset
    always #5 if (clk_run) clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] got);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_eq(tag, {24'h0, got}, {24'h0, e});
    endtask

    // Driver tasks
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.data_in    = d;
        bus_if.data_write = 1'b1;
        @(negedge clk);
        bus_if.data_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_if.address = a;
        #1 d = bus_if.data_out;
    endtask

    task automatic wait_slot(input int idx, input int ph, input string tag);
        int  n;
        bit  ok;
        n  = 0;
        ok = 0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            bus_if.address = 4'h8;
            #1;
            if (bus_if.data_out[6:4] == idx[2:0] && bus_if.data_out[3:0] == ph[3:0]) ok = 1;
            n++;
        end
        check_eq({tag, "_reach"}, 32'(ok), 32'd1);
    endtask

    task automatic sample_uo(input string tag);
        @(negedge clk);
        sb_check(tag, uo_out);
    endtask

    // Scoreboard-driven test sequence
    initial begin
        logic [7:0] rd;
        int t0, t1, lit_cnt;
        bus_if.address    = 4'h0;
        bus_if.data_in    = 8'h00;
        bus_if.data_write = 1'b0;

        // 1: reset values
        repeat (3) @(posedge clk);
        #1 check_eq("rst_uo_low", {24'h0, uo_out}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_uo", {24'h0, uo_out}, 32'h00);
        bus_read(4'h5, rd); check_eq("rst_ctrl", {24'h0, rd}, 32'h70);
        bus_read(4'h6, rd); check_eq("rst_pre", {24'h0, rd}, 32'h3F);
        bus_read(4'h7, rd); check_eq("rst_bright", {24'h0, rd}, 32'h0F);
        bus_read(4'h8, rd); check_eq("rst_status", {24'h0, rd}, 32'h00);
        bus_read(4'hB, rd); check_eq("rd_0xB", {24'h0, rd}, 32'hFF);
        bus_read(4'hA, rd); check_eq("rd_ui_in", {24'h0, rd}, 32'hA5);

        // Register masking
        bus_write(4'h2, 8'h5A); bus_read(4'h2, rd); check_eq("rd_unused_nib", {24'h0, rd}, 32'h00);
        bus_write(4'h4, 8'hFF); bus_read(4'h4, rd); check_eq("rd_dp_mask", {24'h0, rd}, 32'h0F);
        bus_write(4'h7, 8'hFF); bus_read(4'h7, rd); check_eq("rd_bright_mask", {24'h0, rd}, 32'h0F);
        bus_write(4'h4, 8'h00);

        // 2: basic scan
        bus_write(4'h0, 8'h21);
        bus_write(4'h1, 8'h43);
        bus_write(4'h9, 8'h01);
        bus_write(4'h6, 8'h00);
        bus_write(4'h5, 8'hF0);
        exp_q.push_back(8'h06); exp_q.push_back(8'h5B);
        exp_q.push_back(8'h4F); exp_q.push_back(8'h66);
        for (int k = 0; k < 4; k++) begin
            wait_slot(k, 8, $sformatf("t2_slot%0d", k));
            sample_uo($sformatf("t2_dig%0d", k));
        end
        wait_slot(1, 0, "t2_len_a"); t0 = cyc;
        wait_slot(2, 0, "t2_len_b"); t1 = cyc;
        check_eq("t2_slot_len", 32'(t1 - t0), 32'd256);
        wait_slot(0, 0, "t2_frm_a"); t0 = cyc;
        wait_slot(3, 0, "t2_frm_b");
        wait_slot(0, 0, "t2_frm_c"); t1 = cyc;
        check_eq("t2_frame_len", 32'(t1 - t0), 32'd1024);

        // 3: PWM duty with BRIGHT=3
        bus_write(4'h7, 8'h03);
        wait_slot(1, 0, "t3_start");
        lit_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (uo_out != 8'h00) lit_cnt++;
        end
        check_eq("t3_lit_clks", 32'(lit_cnt), 32'd64);
        exp_q.push_back(8'h4F); exp_q.push_back(8'h00);
        wait_slot(2, 2, "t3_on");  sample_uo("t3_dig2_on");
        wait_slot(2, 10, "t3_off"); sample_uo("t3_dig2_off");
        for (int p = 0; p < 16; p++) wait_slot(3, p, $sformatf("t3_phase%0d", p));

        // 4: ripple blanking and decimal points
        bus_write(4'h5, 8'h00);
        bus_write(4'h7, 8'h0F);
        bus_write(4'h0, 8'h50);
        bus_write(4'h1, 8'h00);
        bus_write(4'h4, 8'h04);
        bus_write(4'h9, 8'h01);
        bus_write(4'h5, 8'hF8);
        exp_q.push_back(8'h66 & 8'h00); exp_q.push_back(8'h80);
        exp_q.push_back(8'h6D); exp_q.push_back(8'h3F);
        for (int k = 3; k >= 0; k--) begin
            wait_slot(k, 8, $sformatf("t4_slot%0d", k));
            sample_uo($sformatf("t4_dig%0d", k));
        end

        // 5: swap deferred to frame boundary
        bus_write(4'h5, 8'h00);
        bus_write(4'h4, 8'h00);
        bus_write(4'h0, 8'h21);
        bus_write(4'h1, 8'h43);
        bus_write(4'h9, 8'h01);
        bus_write(4'h5, 8'hF0);
        wait_slot(1, 4, "t5_start");
        bus_write(4'h0, 8'h88);
        bus_write(4'h9, 8'h01);
        bus_read(4'h8, rd); check_eq("t5_pending_set", {31'h0, rd[7]}, 32'd1);
        exp_q.push_back(8'h5B); exp_q.push_back(8'h66);
        exp_q.push_back(8'h7F); exp_q.push_back(8'h7F);
        wait_slot(1, 12, "t5_d1");
        sample_uo("t5_dig1_old");
        wait_slot(3, 8, "t5_d3");
        bus_read(4'h8, rd); check_eq("t5_pending_hold", {31'h0, rd[7]}, 32'd1);
        sample_uo("t5_dig3");
        wait_slot(0, 8, "t5_d0");
        sample_uo("t5_dig0_new");
        bus_read(4'h8, rd); check_eq("t5_pending_clr", {31'h0, rd[7]}, 32'd0);
        wait_slot(1, 8, "t5_d1n");
        sample_uo("t5_dig1_new");

        // 6: frame sync with inverted polarity, then async reset
        bus_write(4'h5, 8'hE4);
        exp_q.push_back(8'h00); exp_q.push_back(8'h80);
        exp_q.push_back(8'hB0); exp_q.push_back(8'h99);
        for (int k = 0; k < 4; k++) begin
            wait_slot(k, 8, $sformatf("t6_slot%0d", k));
            sample_uo($sformatf("t6_dig%0d", k));
        end
        wait_slot(3, 10, "t6_mid");
        clk_run = 1'b0;
        #3 check_eq("t6_pre_reset", {24'h0, uo_out}, 32'h99);
        rst_n = 1'b0;
        #1 check_eq("t6_reset_uo", {24'h0, uo_out}, 32'h00);
        bus_if.address = 4'h5;
        #1 check_eq("t6_reset_ctrl", {24'h0, bus_if.data_out}, 32'h70);
        bus_if.address = 4'h0;
        #1 check_eq("t6_reset_shadow", {24'h0, bus_if.data_out}, 32'h00);
        #10 rst_n = 1'b1;
        clk_run = 1'b1;
        repeat (3) @(posedge clk);
        bus_read(4'h8, rd); check_eq("t6_post_status", {24'h0, rd}, 32'h00);
        check_eq("t6_post_uo", {24'h0, uo_out}, 32'h00);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
